pipeline_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 8 +
 rtl/pipeline_ctrl_if.sv | 19 +
 rtl/pipeline_ctrl_forward_unit.sv | 15 +
 rtl/pipeline_ctrl.sv | 78 +++++++
 tb/tb_pipeline_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard controller
package pipe_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} ctrl_state_e;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from the datapath and stall/flush/forward controls back to it
interface pipeline_ctrl_if;
  import pipe_pkg::*;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  fwd_sel_e   ForwardAE, ForwardBE;
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE,
           RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr, ForwardAE, ForwardBE
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE,
           RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/pipeline_ctrl_forward_unit.sv
// forward_unit: operand bypass select, memory stage wins over writeback
module forward_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rdm,
  input  logic [4:0] rdw,
  input  logic       regwritem,
  input  logic       regwritew,
  output fwd_sel_e   sel
);
  always_comb
    sel = (regwritem && rdm != 5'd0 && rdm == rs) ? FWD_MEM :
          (regwritew && rdw != 5'd0 && rdw == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: load-use/redirect/memory-wait hazard sequencer with sticky timeout error
// Optional PIPE_CTRL_PERF_EN adds StallCycles, LwBubbles and Redirects counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]         StallCycles,
  output logic [31:0]         LwBubbles,
  output logic [31:0]         Redirects,
`endif
  pipeline_ctrl_if.slave      bus
);
  ctrl_state_e      state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             mem_wait, mem_stall, lw_hit, lw_stall, redirect;
  assign cnt_inc   = &cnt ? cnt : cnt + 1'b1;
  assign mem_wait  = bus.MemReqM & ~bus.MemReadyM;
  assign mem_stall = mem_wait | (state == ERR);
  assign lw_hit    = (bus.ResultSrcE == RESULT_MEM) && (bus.RdE != 5'd0) &&
                     (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
  // A redirect during a memory hold is deferred; ID/EX is frozen so PCSrcE persists.
  assign redirect  = bus.PCSrcE & ~mem_stall;
  assign lw_stall  = lw_hit & ~mem_stall & ~bus.PCSrcE;
  always_comb begin
    bus.StallF = mem_stall | lw_stall;
    bus.StallD = mem_stall | lw_stall;
    bus.StallE = mem_stall;
    bus.StallM = mem_stall;
    bus.FlushD = redirect;
    bus.FlushE = redirect | lw_stall;
    bus.FlushW = mem_stall;
  end
  forward_unit u_fwd_a (
    .rs(bus.Rs1E), .rdm(bus.RdM), .rdw(bus.RdW),
    .regwritem(bus.RegWriteM), .regwritew(bus.RegWriteW), .sel(bus.ForwardAE)
  );
  forward_unit u_fwd_b (
    .rs(bus.Rs2E), .rdm(bus.RdM), .rdw(bus.RdW),
    .regwritem(bus.RegWriteM), .regwritew(bus.RegWriteW), .sel(bus.ForwardBE)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      bus.MemErr <= 1'b0;
    end else if (state == RUN) begin
      cnt <= '0;
      if (mem_wait) state <= MEM_WAIT;
    end else if (state == MEM_WAIT) begin
      if (bus.MemReadyM) state <= RUN;
      else begin
        cnt <= cnt_inc;
        if (int'(cnt_inc) >= MEM_TIMEOUT) begin
          state      <= ERR;
          bus.MemErr <= 1'b1;
        end
      end
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCycles <= '0;
      LwBubbles   <= '0;
      Redirects   <= '0;
    end else begin
      StallCycles <= StallCycles + 32'(mem_stall);
      LwBubbles   <= LwBubbles + 32'(lw_stall);
      Redirects   <= Redirects + 32'(redirect);
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of hazard, forwarding, memory-wait and timeout behaviour
module tb_pipeline_ctrl;
  import pipe_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n = 0;
  int   errs = 0;
  pipeline_ctrl_if bus ();
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] sc, lb, rd;
`endif
  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PIPE_CTRL_PERF_EN
    .StallCycles(sc),
    .LwBubbles(lb),
    .Redirects(rd),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE, MemErr}
  localparam logic [11:0] IDLE = 12'b0000_000_00_00_0;
  localparam logic [11:0] LW   = 12'b1100_010_00_00_0;
  localparam logic [11:0] BR   = 12'b0000_110_00_00_0;
  localparam logic [11:0] MS   = 12'b1111_001_00_00_0;
  localparam logic [11:0] ERRV = 12'b1111_001_00_00_1;
  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE, bus.FlushW,
           bus.ForwardAE, bus.ForwardBE, bus.MemErr};
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chks(input string tag, input ctrl_state_e exp);
    n++;
    assert (dut.state === exp) else begin
      errs++;
      $error("FAIL %s: observed state %0d expected %0d", tag, dut.state, exp);
    end
  endtask
  task automatic idle();
    bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
    bus.RdE = 0; bus.RdM = 0; bus.RdW = 0; bus.ResultSrcE = RESULT_ALU;
    bus.PCSrcE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
    bus.MemReqM = 0; bus.MemReadyM = 0;
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  initial begin
    idle();
    step();
    chk("reset_outputs", IDLE);
    chks("reset_state", RUN);
    rst = 1'b0;
    step();
    chk("idle", IDLE);
    bus.ResultSrcE = RESULT_MEM; bus.RdE = 5; bus.Rs1D = 5;
    #1 chk("loaduse_rs1", LW);
    step();
    bus.ResultSrcE = RESULT_ALU; bus.RdE = 0;
    #1 chk("loaduse_released", IDLE);
    bus.ResultSrcE = RESULT_MEM; bus.RdE = 0; bus.Rs1D = 0;
    #1 chk("loaduse_rd0", IDLE);
    bus.RdE = 7; bus.Rs2D = 7; bus.Rs1D = 2;
    #1 chk("loaduse_rs2", LW);
    bus.ResultSrcE = RESULT_PC4;
    #1 chk("pc4_no_stall", IDLE);
    bus.ResultSrcE = RESULT_MEM; bus.PCSrcE = 1;
    #1 chk("redirect_over_lw", BR);
    idle();
    bus.PCSrcE = 1;
    #1 chk("redirect", BR);
    idle();
    step();
    bus.RdM = 3; bus.RdW = 3; bus.RegWriteM = 1; bus.RegWriteW = 1; bus.Rs1E = 3;
    #1 chk("fwd_a_mem", 12'b0000_000_10_00_0);
    bus.Rs2E = 3;
    #1 chk("fwd_ab_mem", 12'b0000_000_10_10_0);
    bus.RegWriteM = 0;
    #1 chk("fwd_ab_wb", 12'b0000_000_01_01_0);
    bus.Rs1E = 0;
    #1 chk("fwd_a_rf", 12'b0000_000_00_01_0);
    bus.RdW = 0; bus.Rs2E = 0;
    #1 chk("fwd_rd0", IDLE);
    idle();
    step();
    bus.MemReqM = 1; bus.MemReadyM = 0;
    #1 chk("mw_c1", MS);
    chks("mw_c1_state", RUN);
    step();
    chk("mw_c2", MS);
    chks("mw_c2_state", MEM_WAIT);
    bus.Rs1E = 9; bus.RdM = 9; bus.RegWriteM = 1;
    #1 chk("mw_fwd_during_stall", 12'b1111_001_10_00_0);
    bus.Rs1E = 0; bus.RdM = 0; bus.RegWriteM = 0;
    step();
    chk("mw_c3", MS);
    step();
    bus.MemReadyM = 1;
    #1 chk("mw_release", IDLE);
    chks("mw_release_state", MEM_WAIT);
    step();
    idle();
    #1 chk("mw_after", IDLE);
    chks("mw_after_state", RUN);
    bus.MemReqM = 1; bus.MemReadyM = 1;
    #1 chk("mw_zero_wait", IDLE);
    step();
    chks("mw_zero_wait_state", RUN);
    bus.MemReadyM = 0; bus.PCSrcE = 1;
    #1 chk("br_wait_c1", MS);
    step();
    chk("br_wait_c2", MS);
    step();
    bus.MemReadyM = 1;
    #1 chk("br_release", BR);
    step();
    idle();
    step();
    chks("pre_timeout_state", RUN);
    bus.MemReqM = 1;
    #1 chk("to_run_cycle", MS);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_wait_cycle", MS);
    end
    step();
    chk("to_err", ERRV);
    chks("to_err_state", ERR);
    bus.MemReqM = 0; bus.PCSrcE = 1;
    #1 chk("err_hold_no_req", ERRV);
    step();
    chk("err_sticky", ERRV);
    #2 rst = 1'b1;
    bus.PCSrcE = 0;
    #1 chk("err_async_reset", IDLE);
    chks("err_async_reset_state", RUN);
    step();
    rst = 1'b0;
    step();
    chk("post_reset_idle", IDLE);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
